// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed 7-segment scanner with tear-free frame loads,
// leading-zero blanking and per-slot PWM brightness.
module seg_scan_driver #(
   parameter int CLK_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_in,
   input  logic [3:0]  dp_in,
   input  logic        data_load,
   input  logic        blank_lz,
   input  logic [2:0]  brightness,
   output logic [3:0]  sel,
   output logic [7:0]  seg,
   output logic        frame_done
);
   localparam int PW = $clog2(CLK_DIV);
   localparam int MW = PW + 4;
   logic [PW-1:0] presc;
   logic [1:0]    idx;
   logic [15:0]   disp, pend;
   logic [3:0]    disp_dp, pend_dp;
   logic          pend_v;
   logic          tick, wrap, on, blank;
   logic [3:0]    lz, nib, sel_n;
   logic [6:0]    code;
   logic [7:0]    seg_n;
   logic [MW-1:0] pwm_pos, pwm_lim;
   assign tick = presc == PW'(CLK_DIV - 1);
   assign wrap = tick && idx == 2'd3;
   // (brightness+1)*CLK_DIV peaks at 8*CLK_DIV, which still fits in MW bits
   assign pwm_pos = MW'(presc) << 3;
   assign pwm_lim = MW'(brightness) * MW'(CLK_DIV) + MW'(CLK_DIV);
   assign on = pwm_pos < pwm_lim;
   assign lz[3] = disp[15:12] == 4'h0;
   assign lz[2] = lz[3] && disp[11:8] == 4'h0;
   assign lz[1] = lz[2] && disp[7:4] == 4'h0;
   assign lz[0] = 1'b0;
   assign blank = blank_lz && lz[idx];
   assign nib = disp[{idx, 2'b00} +: 4];
   always_comb begin
      code = 7'h00;
      case (nib)
         4'h0: code = 7'h3F;
         4'h1: code = 7'h06;
         4'h2: code = 7'h5B;
         4'h3: code = 7'h4F;
         4'h4: code = 7'h66;
         4'h5: code = 7'h6D;
         4'h6: code = 7'h7D;
         4'h7: code = 7'h07;
         4'h8: code = 7'h7F;
         4'h9: code = 7'h6F;
         4'hA: code = 7'h77;
         4'hB: code = 7'h7C;
         4'hC: code = 7'h39;
         4'hD: code = 7'h5E;
         4'hE: code = 7'h79;
         4'hF: code = 7'h71;
         default: code = 7'h00;
      endcase
   end
   assign sel_n = (on && !blank) ? ~(4'b0001 << idx) : 4'hF;
   assign seg_n = (on && !blank) ? ~{disp_dp[idx], code} : 8'hFF;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc      <= '0;
         idx        <= 2'd0;
         disp       <= 16'h0000;
         disp_dp    <= 4'h0;
         pend       <= 16'h0000;
         pend_dp    <= 4'h0;
         pend_v     <= 1'b0;
         sel        <= 4'hF;
         seg        <= 8'hFF;
         frame_done <= 1'b0;
      end else begin
         presc      <= tick ? '0 : presc + 1'b1;
         idx        <= tick ? idx + 2'd1 : idx;
         frame_done <= wrap;
         sel        <= sel_n;
         seg        <= seg_n;
         // the display only changes at a frame boundary so a frame never tears
         if (wrap && data_load) begin
            disp    <= data_in;
            disp_dp <= dp_in;
            pend_v  <= 1'b0;
         end else if (wrap && pend_v) begin
            disp    <= pend;
            disp_dp <= pend_dp;
            pend_v  <= 1'b0;
         end else if (data_load) begin
            pend    <= data_in;
            pend_dp <= dp_in;
            pend_v  <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed scan/load/blank/PWM vectors; expected {frame_done,sel,seg}
// per cycle are queued by the stimulus and popped by an independent negedge monitor.
module tb_seg_scan_driver;
   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] data_in;
   logic [3:0]  dp_in;
   logic        data_load;
   logic        blank_lz;
   logic [2:0]  brightness;
   logic [3:0]  sel;
   logic [7:0]  seg;
   logic        frame_done;
   logic [12:0] q[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   always #5 clk = ~clk;
   seg_scan_driver #(.CLK_DIV(8)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .dp_in(dp_in), .data_load(data_load),
      .blank_lz(blank_lz), .brightness(brightness), .sel(sel), .seg(seg), .frame_done(frame_done)
   );
   always @(negedge clk) begin
      logic [12:0] e;
      if (q.size() > 0) begin
         e = q.pop_front();
         n_cmp++;
         if ({frame_done, sel, seg} !== e) begin
            n_bad++;
            $display("FAIL out[%0d] @%0t: got fd=%b sel=%h seg=%h, required fd=%b sel=%h seg=%h",
                     n_cmp, $time, frame_done, sel, seg, e[12], e[11:8], e[7:0]);
         end
      end
   end
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask
   task automatic push(input logic [3:0] s, input logic [7:0] g, input logic fd);
      q.push_back({fd, s, g});
   endtask
   task automatic push_slot(input logic [3:0] s, input logic [7:0] g, input int on, input logic last);
      for (int i = 0; i < 8; i++) push(i < on ? s : 4'hF, i < on ? g : 8'hFF, last && i == 7);
   endtask
   task automatic push_frame(input logic [7:0] g0, g1, g2, g3, input int on, input logic [3:0] blank);
      push_slot(4'hE, g0, blank[0] ? 0 : on, 1'b0);
      push_slot(4'hD, g1, blank[1] ? 0 : on, 1'b0);
      push_slot(4'hB, g2, blank[2] ? 0 : on, 1'b0);
      push_slot(4'h7, g3, blank[3] ? 0 : on, 1'b1);
   endtask
   task automatic reset_phase();
      rst = 1'b1;
      push(4'hF, 8'hFF, 1'b0);
      cyc(1);
      push(4'hF, 8'hFF, 1'b0);
      cyc(1);
      rst = 1'b0;
      push(4'hF, 8'hFF, 1'b0);
   endtask
   task automatic load(input logic [15:0] d, input logic [3:0] p);
      data_in   = d;
      dp_in     = p;
      data_load = 1'b1;
      cyc(1);
      data_load = 1'b0;
   endtask
   task automatic drain();
      int t = 0;
      while (q.size() > 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      #2;
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d entries left, required 0", q.size());
         q.delete();
      end
   endtask
   initial begin
      rst        = 1'b1;
      data_in    = 16'h0000;
      dp_in      = 4'h0;
      data_load  = 1'b0;
      blank_lz   = 1'b0;
      brightness = 3'd7;
      cyc(1);
      // scan at full brightness, last-wins loads, mid-frame load deferred one frame
      reset_phase();
      push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 8, 4'b0000);
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 8, 4'b0000);
      push_frame(8'h99, 8'hB0, 8'hA4, 8'hF9, 8, 4'b0000);
      push_frame(8'hA1, 8'hC6, 8'h83, 8'h88, 8, 4'b0000);
      cyc(5);
      load(16'h5555, 4'h0);
      cyc(4);
      load(16'h1234, 4'h0);
      cyc(63);
      load(16'hABCD, 4'h0);
      drain();
      // mid-slot reset discards a pending load; then a load on the wrap tick
      reset_phase();
      for (int i = 0; i < 8; i++) push(4'hE, 8'hC0, 1'b0);
      for (int i = 0; i < 3; i++) push(4'hD, 8'hC0, 1'b0);
      cyc(3);
      load(16'h1234, 4'h0);
      cyc(8);
      blank_lz = 1'b1;
      reset_phase();
      push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8, 4'b1110);
      push_frame(8'hC0, 8'hFF, 8'hFF, 8'hFF, 8, 4'b1110);
      push_frame(8'hC0, 8'h8E, 8'hFF, 8'hFF, 8, 4'b1100);
      push_frame(8'hC0, 8'h8E, 8'hFF, 8'hFF, 8, 4'b1100);
      cyc(63);
      load(16'h00F0, 4'h0);
      drain();
      // PWM duty and decimal point
      blank_lz   = 1'b0;
      brightness = 3'd0;
      reset_phase();
      push_frame(8'hC0, 8'hC0, 8'hC0, 8'hC0, 1, 4'b0000);
      push_frame(8'h40, 8'hC0, 8'hC0, 8'hC0, 1, 4'b0000);
      push_frame(8'h40, 8'hC0, 8'hC0, 8'hC0, 4, 4'b0000);
      push_frame(8'h40, 8'hFF, 8'hFF, 8'hFF, 4, 4'b1110);
      cyc(31);
      load(16'h0000, 4'b0001);
      cyc(31);
      brightness = 3'd3;
      cyc(32);
      blank_lz = 1'b1;
      drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
